// File: rtl/execute_mdu.sv
// Execute stage: single-cycle ALU with next-PC selection plus an iterative
// RV32M multiply/divide unit, behind a registered valid/ready output stage.
// Optional build macro: MDU_FAST_MUL_EN selects a single-cycle multiplier.
module execute_mdu #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_valA,
  input  logic [XLEN-1:0] in_valB,
  input  logic [XLEN-1:0] in_imm,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_pre_pc,
  input  logic [1:0]      in_alu_valA_sel,
  input  logic [1:0]      in_alu_valB_sel,
  input  logic [3:0]      in_alu_func_sel,
  input  logic            in_md_en,
  input  logic [2:0]      in_md_op,
  input  logic            in_need_jump,
  input  logic            in_is_jalr,
  input  logic            in_is_ecall,
  input  logic            in_is_mret,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_valE,
  output logic [XLEN-1:0] out_pre_pc,
  output logic            out_need_jump,
  output logic            busy
);
  localparam int SH_W = $clog2(XLEN);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   mcand_q, mcand_d;
  logic              neg_q, neg_d;
  logic [2:0]        op_q, op_d;
  logic [XLEN-1:0]   valE_q, valE_d, pre_pc_q, pre_pc_d;
  logic              jump_q, jump_d;

  logic [XLEN-1:0] op_a, op_b, alu_res, npc;
  logic            accept;

  assign in_ready = !rst && !flush &&
                    (state_q == S_IDLE || (state_q == S_DONE && out_ready));
  assign accept        = in_valid && in_ready;
  assign out_valid     = (state_q == S_DONE);
  assign busy          = (state_q == S_CALC);
  assign out_valE      = valE_q;
  assign out_pre_pc    = pre_pc_q;
  assign out_need_jump = jump_q;

  // ALU operand muxing, function select and next-PC choice
  always_comb begin
    case (in_alu_valA_sel)
      2'd0:    op_a = in_valA;
      2'd1:    op_a = in_pc;
      default: op_a = '0;
    endcase
    op_b = (in_alu_valB_sel == 2'd1) ? in_imm : in_valB;
    case (in_alu_func_sel)
      4'd0:    alu_res = op_a;
      4'd1:    alu_res = op_a + op_b;
      4'd2:    alu_res = op_a - op_b;
      4'd3:    alu_res = op_a << op_b[SH_W-1:0];
      4'd4:    alu_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      4'd5:    alu_res = {{(XLEN-1){1'b0}}, op_a < op_b};
      4'd6:    alu_res = op_a ^ op_b;
      4'd7:    alu_res = op_a >> op_b[SH_W-1:0];
      4'd8:    alu_res = $unsigned($signed(op_a) >>> op_b[SH_W-1:0]);
      4'd9:    alu_res = op_a | op_b;
      4'd10:   alu_res = op_a & op_b;
      default: alu_res = '0;
    endcase
    if (in_is_jalr)                    npc = {alu_res[XLEN-1:1], 1'b0};
    else if (in_is_ecall || in_is_mret) npc = op_b;
    else if (in_need_jump)             npc = alu_res;
    else                               npc = in_pre_pc;
  end

  // MDU accept-time decode: operand magnitudes, result sign, special cases
  logic            is_mul, a_neg, b_neg, div_zero, div_ovf, md_special, md_neg;
  logic [XLEN-1:0] a_mag, b_mag, md_special_res;
`ifdef MDU_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_mag, fast_prod;
`endif
  always_comb begin
    is_mul   = !in_md_op[2];
    // MULH/MULHSU/DIV/REM treat A as signed; MULH/DIV/REM treat B as signed
    a_neg    = in_valA[XLEN-1] && (in_md_op == 3'd1 || in_md_op == 3'd2 ||
                                   in_md_op == 3'd4 || in_md_op == 3'd6);
    b_neg    = in_valB[XLEN-1] && (in_md_op == 3'd1 || in_md_op == 3'd4 ||
                                   in_md_op == 3'd6);
    a_mag    = a_neg ? -in_valA : in_valA;
    b_mag    = b_neg ? -in_valB : in_valB;
    // remainders follow the dividend sign, everything else A^B
    md_neg   = (in_md_op[2] && in_md_op[1]) ? a_neg : (a_neg ^ b_neg);
    div_zero = !is_mul && (in_valB == '0);
    div_ovf  = !is_mul && !in_md_op[0] && (in_valA == MIN_NEG) && (in_valB == '1);
    md_special     = div_zero || div_ovf;
    md_special_res = '0;
    if (div_zero)     md_special_res = in_md_op[1] ? in_valA : '1;
    else if (div_ovf) md_special_res = in_md_op[1] ? '0 : in_valA;
`ifdef MDU_FAST_MUL_EN
    fast_mag  = a_mag * b_mag;
    fast_prod = (a_neg ^ b_neg) ? -fast_mag : fast_mag;
    if (is_mul) begin
      md_special     = 1'b1;
      md_special_res = (in_md_op == 3'd0) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
    end
`endif
  end

  // One shift-add or restoring-divide iteration plus final sign fix-up
  logic [XLEN:0]     mul_sum, rem_sh, rem_diff;
  logic [2*XLEN-1:0] step, fin_prod;
  logic [XLEN-1:0]   div_val, final_res;
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    rem_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    rem_diff = rem_sh - {1'b0, mcand_q};
    if (!op_q[2]) step = {mul_sum, acc_q[XLEN-1:1]};
    else if (!rem_diff[XLEN]) step = {rem_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    else step = {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    fin_prod = neg_q ? -step : step;
    div_val  = op_q[1] ? step[2*XLEN-1:XLEN] : step[XLEN-1:0];
    if (!op_q[2]) final_res = (op_q == 3'd0) ? fin_prod[XLEN-1:0] : fin_prod[2*XLEN-1:XLEN];
    else          final_res = neg_q ? -div_val : div_val;
  end

  // Next-state and register-load logic for the control FSM and result stage
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    neg_d    = neg_q;
    op_d     = op_q;
    valE_d   = valE_q;
    pre_pc_d = pre_pc_q;
    jump_d   = jump_q;
    if (flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else if (accept) begin
      op_d     = in_md_op;
      neg_d    = md_neg;
      cnt_d    = '0;
      pre_pc_d = in_md_en ? in_pre_pc : npc;
      jump_d   = !in_md_en && (in_need_jump || in_is_jalr || in_is_ecall || in_is_mret);
      if (in_md_en && !md_special) begin
        state_d = S_CALC;
        acc_d   = {{XLEN{1'b0}}, is_mul ? b_mag : a_mag};
        mcand_d = is_mul ? a_mag : b_mag;
      end else begin
        state_d = S_DONE;
        valE_d  = in_md_en ? md_special_res : alu_res;
      end
    end else begin
      case (state_q)
        S_CALC: begin
          acc_d = step;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LIMIT) begin
            state_d = S_DONE;
            valE_d  = final_res;
          end
        end
        S_DONE:  if (out_ready) state_d = S_IDLE;
        default: ;
      endcase
    end
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      neg_q    <= 1'b0;
      op_q     <= '0;
      valE_q   <= '0;
      pre_pc_q <= '0;
      jump_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      neg_q    <= neg_d;
      op_q     <= op_d;
      valE_q   <= valE_d;
      pre_pc_q <= pre_pc_d;
      jump_q   <= jump_d;
    end
  end
endmodule
